// File: rtl/stream_mux_arb_if.sv
// Stream mux bundle: NUM_IN producer channels in, one registered consumer channel out.
// The producer/consumer side (bench or surrounding logic) uses the master modport;
// the mux itself uses the slave modport.
interface stream_mux_arb_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4
);
    localparam int SEL_W = $clog2(NUM_IN);

    logic [SEL_W-1:0]        sel;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_last;
    logic [NUM_IN-1:0]       in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_last;
    logic [SEL_W-1:0]        out_src;
    logic                    out_ready;

    modport master (
        output sel, in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_last, out_src
    );

    modport slave (
        input  sel, in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_last, out_src
    );
endinterface

// File: rtl/stream_mux_arb.sv
// N:1 packet-aware stream multiplexer with a registered output stage.
// MODE 0 = round-robin, 1 = fixed priority (lowest index), 2 = external select.
// A beat with last=0 locks the grant to its channel until that channel's last beat.
module stream_mux_arb #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int MODE   = 0
) (
    input  logic              clk,
    input  logic              rst,
    stream_mux_arb_if.slave   bus
);
    localparam int SEL_W = $clog2(NUM_IN);

    logic [WIDTH-1:0]  out_data_q,  out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q,  out_last_d;
    logic [SEL_W-1:0]  out_src_q,   out_src_d;
    logic              lock_q,      lock_d;
    logic [SEL_W-1:0]  lock_idx_q,  lock_idx_d;
    logic [SEL_W-1:0]  rr_ptr_q,    rr_ptr_d;

    logic [NUM_IN-1:0] grant;
    logic [SEL_W-1:0]  grant_idx;
    logic              load;
    logic              xfer;
    logic [WIDTH-1:0]  sel_data;
    logic              sel_last;

    // The output register can accept a beat when empty or when its beat leaves this cycle.
    assign load = !out_valid_q | bus.out_ready;

    // One-hot grant: the locked channel only, otherwise per arbitration mode.
    always_comb begin : grant_logic
        int  idx;
        logic found;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        if (lock_q) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (int'(lock_idx_q) == i) grant[i] = bus.in_valid[i];
            end
        end else begin
            case (MODE)
                0: begin
                    for (int off = 1; off <= NUM_IN; off++) begin
                        idx = (int'(rr_ptr_q) + off) % NUM_IN;
                        if (!found && bus.in_valid[idx]) begin
                            grant[idx] = 1'b1;
                            found      = 1'b1;
                        end
                    end
                end
                1: begin
                    for (int i = 0; i < NUM_IN; i++) begin
                        if (!found && bus.in_valid[i]) begin
                            grant[i] = 1'b1;
                            found    = 1'b1;
                        end
                    end
                end
                default: begin
                    // An out-of-range sel matches no channel, so nothing is granted.
                    for (int i = 0; i < NUM_IN; i++) begin
                        if (int'(bus.sel) == i) grant[i] = bus.in_valid[i];
                    end
                end
            endcase
        end
    end

    // Encode the one-hot grant and pick the granted channel's payload.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant[i]) grant_idx = SEL_W'(i);
        end
        sel_data = bus.in_data[int'(grant_idx)*WIDTH +: WIDTH];
        sel_last = bus.in_last[grant_idx];
    end

    assign xfer         = load & (|grant);
    assign bus.in_ready = grant & {NUM_IN{load}};

    // Next state of the output stage, lock and round-robin pointer.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_src_d   = out_src_q;
        lock_d      = lock_q;
        lock_idx_d  = lock_idx_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_data_d  = sel_data;
            out_valid_d = 1'b1;
            out_last_d  = sel_last;
            out_src_d   = grant_idx;
            lock_d      = !sel_last;
            lock_idx_d  = grant_idx;
            rr_ptr_d    = grant_idx;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset drops any held beat and lock, and points rr at the last channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
            lock_q      <= 1'b0;
            lock_idx_q  <= '0;
            rr_ptr_q    <= SEL_W'(NUM_IN - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_src_q   <= out_src_d;
            lock_q      <= lock_d;
            lock_idx_q  <= lock_idx_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_src   = out_src_q;
endmodule
